mux_adder_pipe: RTL and testbench

Parametrised, pipelined N-bit adder/subtractor built from 2:1-mux full-adder cells, with a valid/ready handshake on both sides. Operands are split into LANE-bit slices; each pipeline stage resolves one slice and passes its carry to the next, so wide adds close timing at one slice of ripple per cycle. It is the sequential, multi-bit successor to the single-bit mux full adder and is used as the arithmetic datapath element feeding downstream accumulator and ALU blocks.

---
 rtl/mux_adder_pipe_if.sv | 27 ++
 rtl/mux_adder_pipe.sv | 111 +++++++++++
 tb/tb_mux_adder_pipe.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mux_adder_pipe_if.sv
// Handshake and operand/result bundle for the pipelined mux-cell adder.
// The master side produces operands and consumes results; the slave side is the adder.
interface mux_adder_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/mux_adder_pipe.sv
// Pipelined WIDTH-bit adder/subtractor built from 2:1-mux full-adder cells.
// Each register stage resolves one LANE-bit slice and hands its carry to the next stage.
// Operands ride along in skew registers and finished low slices are forwarded with
// the beat, so every stage holds one coherent beat. A single advance enable freezes
// the whole pipe when the consumer stalls; bubbles are kept, not collapsed.
// WIDTH must be a multiple of LANE.
module mux_adder_pipe #(
  parameter int WIDTH = 8,
  parameter int LANE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  mux_adder_pipe_if.slave  io
);

  localparam int STAGES = WIDTH / LANE;

  // Stage registers: index k holds the beat after slice k has been resolved.
  logic [STAGES-1:0]            v_q;
  logic [STAGES-1:0]            c_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_q;
  logic [STAGES-1:0][WIDTH-1:0] s_q;
  logic                         ovf_q;

  // What each stage sees as its input beat, and what it will register.
  logic [STAGES-1:0]            v_src;
  logic [STAGES-1:0]            c_src;
  logic [STAGES-1:0][WIDTH-1:0] a_src;
  logic [STAGES-1:0][WIDTH-1:0] b_src;
  logic [STAGES-1:0][WIDTH-1:0] s_src;
  logic [STAGES-1:0][WIDTH-1:0] s_n;
  logic [STAGES-1:0]            c_n;
  logic                         ovf_n;
  logic [LANE+1:0]              slice_r;
  logic                         adv;

  // One LANE-bit ripple of mux full-adder cells.
  // Returns {carry out, carry into the top bit of the slice, slice sum}.
  function automatic logic [LANE+1:0] slice_add(
    input logic [LANE-1:0] x,
    input logic [LANE-1:0] y,
    input logic            c
  );
    logic [LANE-1:0] s;
    logic            carry;
    logic            cmsb;
    s     = '0;
    carry = c;
    cmsb  = c;
    for (int i = 0; i < LANE; i++) begin
      cmsb  = carry;
      s[i]  = x[i] ? ~(y[i] ^ carry) : (y[i] ^ carry);
      carry = x[i] ? (y[i] | carry) : (y[i] & carry);
    end
    return {carry, cmsb, s};
  endfunction

  assign adv          = !v_q[STAGES-1] || io.out_ready;
  assign io.in_ready  = adv;
  assign io.out_valid = v_q[STAGES-1];
  assign io.sum       = s_q[STAGES-1];
  assign io.cout      = c_q[STAGES-1];
  assign io.ovf       = ovf_q;

  // Route each stage's input beat and resolve its slice; the last stage also derives overflow.
  always_comb begin
    v_src[0] = io.in_valid;
    a_src[0] = io.a;
    b_src[0] = io.b ^ {WIDTH{io.sub}};
    c_src[0] = io.sub ? 1'b1 : io.cin;
    s_src[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_src[k] = v_q[k-1];
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      c_src[k] = c_q[k-1];
      s_src[k] = s_q[k-1];
    end
    s_n     = s_src;
    c_n     = '0;
    ovf_n   = 1'b0;
    slice_r = '0;
    for (int k = 0; k < STAGES; k++) begin
      slice_r                = slice_add(a_src[k][k*LANE +: LANE], b_src[k][k*LANE +: LANE], c_src[k]);
      s_n[k][k*LANE +: LANE] = slice_r[LANE-1:0];
      c_n[k]                 = slice_r[LANE+1];
      ovf_n                  = slice_r[LANE+1] ^ slice_r[LANE];
    end
  end

  // Advance every stage together, or hold them all while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      v_q   <= v_src;
      c_q   <= c_n;
      a_q   <= a_src;
      b_q   <= b_src;
      s_q   <= s_n;
      ovf_q <= ovf_n;
    end
  end

endmodule

// File: tb/tb_mux_adder_pipe.sv
// Directed and streaming checks for the pipelined mux-cell adder (WIDTH=8, LANE=4).
module tb_mux_adder_pipe;

  localparam int NRAND = 10000;

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;

  logic [7:0] stA   [NRAND];
  logic [7:0] stB   [NRAND];
  logic       stCin [NRAND];
  logic       stSub [NRAND];

  mux_adder_pipe_if #(.WIDTH(8)) io ();

  mux_adder_pipe #(.WIDTH(8), .LANE(4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result packed as {sum, cout, ovf}.
  function automatic logic [9:0] refModel(input logic [7:0] x, input logic [7:0] y,
                                          input logic c, input logic s);
    logic [8:0] t;
    logic [7:0] r;
    logic       co;
    logic       ov;
    if (s) begin
      r  = x - y;
      co = (x >= y);
      ov = (x[7] != y[7]) && (r[7] != x[7]);
    end else begin
      t  = {1'b0, x} + {1'b0, y} + {8'b0, c};
      r  = t[7:0];
      co = t[8];
      ov = (x[7] == y[7]) && (r[7] != x[7]);
    end
    return {r, co, ov};
  endfunction

  // Sends one beat with the consumer always ready and checks latency and result.
  task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input logic sub,
                               input logic [7:0] expSum, input logic expCout, input logic expOvf);
    @(negedge clk);
    io.in_valid  = 1'b1;
    io.a         = a;
    io.b         = b;
    io.cin       = cin;
    io.sub       = sub;
    io.out_ready = 1'b1;
    #1;
    checkOutput({tag, "_in_ready"}, 32'(io.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    io.a        = ~a;
    io.b        = ~b;
    io.cin      = ~cin;
    #1;
    checkOutput({tag, "_not_early"}, 32'(io.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput({tag, "_out_valid"}, 32'(io.out_valid), 32'd1);
    checkOutput({tag, "_sum"}, 32'(io.sum), 32'(expSum));
    checkOutput({tag, "_cout"}, 32'(io.cout), 32'(expCout));
    checkOutput({tag, "_ovf"}, 32'(io.ovf), 32'(expOvf));
  endtask

  // Streams n stored beats; mode 0: always ready, 1: stall 3 cycles at first result, 2: random.
  task automatic runStream(input string tag, input int n, input int mode);
    logic [9:0] expq[$];
    int idx;
    int got;
    int cyc;
    int stallLeft;
    idx       = 0;
    got       = 0;
    cyc       = 0;
    stallLeft = 3;
    while ((got < n) && (cyc < n * 6 + 100)) begin
      @(negedge clk);
      cyc++;
      if ((idx < n) && ((mode != 2) || ($urandom_range(0, 4) != 0))) begin
        io.in_valid = 1'b1;
        io.a        = stA[idx];
        io.b        = stB[idx];
        io.cin      = stCin[idx];
        io.sub      = stSub[idx];
      end else begin
        io.in_valid = 1'b0;
      end
      if (mode == 0) begin
        io.out_ready = 1'b1;
      end else if (mode == 1) begin
        io.out_ready = !(io.out_valid && (stallLeft > 0));
      end else begin
        io.out_ready = ($urandom_range(0, 3) != 0);
      end
      #1;
      if (io.out_valid && !io.out_ready) begin
        checkOutput({tag, "_stall_in_ready"}, 32'(io.in_ready), 32'd0);
        if (mode == 1) begin
          stallLeft--;
          if (expq.size() > 0)
            checkOutput({tag, "_hold"}, 32'({io.sum, io.cout, io.ovf}), 32'(expq[0]));
        end
      end
      if (io.out_valid && io.out_ready) begin
        if (expq.size() == 0) begin
          checkOutput({tag, "_spurious"}, 32'd1, 32'd0);
        end else begin
          checkOutput({tag, "_result"}, 32'({io.sum, io.cout, io.ovf}), 32'(expq.pop_front()));
        end
        got++;
      end
      if (io.in_valid && io.in_ready) begin
        expq.push_back(refModel(io.a, io.b, io.cin, io.sub));
        idx++;
      end
    end
    checkOutput({tag, "_count"}, 32'(got), 32'(n));
    checkOutput({tag, "_leftover"}, 32'(expq.size()), 32'd0);
    @(negedge clk);
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
  endtask

  // Watchdog so the run always reaches an end.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    assertCount  = 0;
    failCount    = 0;
    rst          = 1'b1;
    io.in_valid  = 1'b0;
    io.a         = 8'h00;
    io.b         = 8'h00;
    io.cin       = 1'b0;
    io.sub       = 1'b0;
    io.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(io.out_valid), 32'd0);
    checkOutput("rst_sum", 32'(io.sum), 32'd0);
    checkOutput("rst_cout", 32'(io.cout), 32'd0);
    checkOutput("rst_ovf", 32'(io.ovf), 32'd0);
    checkOutput("rst_in_ready", 32'(io.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 32'(io.in_ready), 32'd1);

    // Directed add / subtract vectors.
    applyStimulus("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    applyStimulus("add_ff_00_c", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus("sub_00_01", 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    applyStimulus("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    applyStimulus("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    applyStimulus("sub_05_05", 8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);

    // Backpressure: four back-to-back beats, consumer stalls at the first result.
    stA[0] = 8'h10; stB[0] = 8'h20; stCin[0] = 1'b0; stSub[0] = 1'b0;
    stA[1] = 8'hF0; stB[1] = 8'h20; stCin[1] = 1'b1; stSub[1] = 1'b0;
    stA[2] = 8'h05; stB[2] = 8'h07; stCin[2] = 1'b0; stSub[2] = 1'b1;
    stA[3] = 8'h7F; stB[3] = 8'h7F; stCin[3] = 1'b0; stSub[3] = 1'b0;
    runStream("bp", 4, 1);

    // Async reset with two beats in flight.
    @(negedge clk);
    io.in_valid  = 1'b1;
    io.a         = 8'h11;
    io.b         = 8'h22;
    io.cin       = 1'b1;
    io.sub       = 1'b0;
    io.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    io.a = 8'h33;
    io.b = 8'h44;
    @(posedge clk);
    #2;
    checkOutput("mid_pre_valid", 32'(io.out_valid), 32'd1);
    checkOutput("mid_pre_sum", 32'(io.sum), 32'h34);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_out_valid", 32'(io.out_valid), 32'd0);
    checkOutput("mid_rst_sum", 32'(io.sum), 32'd0);
    checkOutput("mid_rst_cout", 32'(io.cout), 32'd0);
    checkOutput("mid_rst_ovf", 32'(io.ovf), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(io.in_ready), 32'd1);
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_rel_in_ready", 32'(io.in_ready), 32'd1);
    checkOutput("mid_rel_out_valid", 32'(io.out_valid), 32'd0);
    applyStimulus("after_rst", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

    // Random sweep with random gaps and random consumer readiness.
    for (int i = 0; i < NRAND; i++) begin
      stA[i]   = 8'($urandom);
      stB[i]   = 8'($urandom);
      stCin[i] = 1'($urandom);
      stSub[i] = 1'($urandom);
    end
    runStream("rand", NRAND, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
